// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - row-multiplexed 8x8 bicolour LED matrix scanner
// Double-buffered frame: shadow catches loads, active swaps in only at the row-0 boundary.
module matrix_scan_driver #(
  parameter int DWELL = 1000,
  parameter int BLANK = 50
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [127:0] frame_data,
  input  logic         frame_valid,
  output logic         frame_ack,
  output logic         frame_sync,
  output logic [7:0]   row_sel,
  output logic [7:0]   col_r,
  output logic [7:0]   col_g
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_row;
  logic [127:0]   r_shadow;
  logic [127:0]   r_active;
  logic           r_pending;
  logic           r_ack;
  logic           r_sync;
  logic [7:0]     r_row_sel;
  logic [7:0]     r_col_r;
  logic [7:0]     r_col_g;

  logic           w_start;
  logic           w_wrap;
  logic           w_boundary;
  logic           w_drive;
  logic [CW-1:0]  w_cnt_nxt;
  logic [2:0]     w_row_nxt;
  logic [15:0]    w_row_bits;
  logic [7:0]     w_col_r;
  logic [7:0]     w_col_g;

  // Next-slot position; outputs are computed from it so they line up with the registered state.
  always_comb begin
    w_start    = en && (r_state == S_IDLE);
    w_wrap     = (r_cnt == CW'(DWELL - 1));
    w_cnt_nxt  = (w_start || w_wrap) ? '0 : r_cnt + CW'(1);
    w_row_nxt  = w_start ? 3'd0 : (w_wrap ? r_row + 3'd1 : r_row);
    w_boundary = w_start || (en && (r_state != S_IDLE) && w_wrap && (r_row == 3'd7));
    w_drive    = (w_cnt_nxt >= CW'(BLANK));
    w_row_bits = r_active[{w_row_nxt, 4'b0000} +: 16];
    w_col_r    = '0;
    w_col_g    = '0;
    for (int c = 0; c < 8; c++) begin
      w_col_r[c] = w_row_bits[2*c];
      w_col_g[c] = w_row_bits[2*c+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_row     <= 3'd0;
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
      r_ack     <= 1'b0;
      r_sync    <= 1'b0;
      r_row_sel <= 8'hFF;
      r_col_r   <= 8'h00;
      r_col_g   <= 8'h00;
    end else begin
      // A load on the boundary cycle bypasses shadow so it shows from this very frame.
      if (w_boundary && frame_valid) begin
        r_active  <= frame_data;
        r_pending <= 1'b0;
        r_ack     <= 1'b1;
      end else if (w_boundary && r_pending) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
        r_ack     <= 1'b1;
      end else begin
        r_ack <= 1'b0;
        if (frame_valid) begin
          r_shadow  <= frame_data;
          r_pending <= 1'b1;
        end
      end
      r_sync <= w_boundary;

      if (!en) begin
        r_state   <= S_IDLE;
        r_cnt     <= '0;
        r_row     <= 3'd0;
        r_row_sel <= 8'hFF;
        r_col_r   <= 8'h00;
        r_col_g   <= 8'h00;
      end else begin
        r_state <= w_drive ? S_DRIVE : S_BLANK;
        r_cnt   <= w_cnt_nxt;
        r_row   <= w_row_nxt;
        if (w_drive) begin
          r_row_sel <= ~(8'b1 << w_row_nxt);
          r_col_r   <= w_col_r;
          r_col_g   <= w_col_g;
        end else begin
          r_row_sel <= 8'hFF;
          r_col_r   <= 8'h00;
          r_col_g   <= 8'h00;
        end
      end
    end
  end

  assign frame_ack  = r_ack;
  assign frame_sync = r_sync;
  assign row_sel    = r_row_sel;
  assign col_r      = r_col_r;
  assign col_g      = r_col_g;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb/tb_matrix_scan_driver.sv - scoreboard bench for matrix_scan_driver (DWELL=4, BLANK=1)
module tb_matrix_scan_driver;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [127:0] frame_data;
  logic         frame_valid;
  logic         frame_ack;
  logic         frame_sync;
  logic [7:0]   row_sel;
  logic [7:0]   col_r;
  logic [7:0]   col_g;

  matrix_scan_driver #(.DWELL(4), .BLANK(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_ack(frame_ack), .frame_sync(frame_sync),
    .row_sel(row_sel), .col_r(col_r), .col_g(col_g)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Record layout: {row_sel, col_r, col_g, frame_sync, frame_ack}
  logic [25:0] q_exp[$];
  logic [25:0] q_act[$];

  // Reference: time-since-enable based scan position plus a double-buffer model.
  logic         m_run = 1'b0;
  int           m_t = 0;
  logic [127:0] m_shadow = '0;
  logic [127:0] m_active = '0;
  logic         m_pend = 1'b0;

  task automatic model_reset();
    m_run = 1'b0; m_t = 0; m_shadow = '0; m_active = '0; m_pend = 1'b0;
  endtask

  task automatic cycle(input logic e, input logic fv, input logic [127:0] fd);
    logic [7:0] rs, cr, cg;
    logic sy, ak;
    int row, ph;
    en = e; frame_valid = fv; frame_data = fd;
    rs = 8'hFF; cr = 8'h00; cg = 8'h00; sy = 1'b0; ak = 1'b0;
    if (!e) begin
      m_run = 1'b0;
      if (fv) begin m_shadow = fd; m_pend = 1'b1; end
    end else begin
      m_t = m_run ? m_t + 1 : 0;
      m_run = 1'b1;
      sy = ((m_t % 32) == 0);
      if (sy && fv) begin m_active = fd; m_pend = 1'b0; ak = 1'b1; end
      else if (sy && m_pend) begin m_active = m_shadow; m_pend = 1'b0; ak = 1'b1; end
      else if (fv) begin m_shadow = fd; m_pend = 1'b1; end
      row = (m_t / 4) % 8;
      ph  = m_t % 4;
      if (ph != 0) begin
        rs = ~(8'h01 << row);
        for (int c = 0; c < 8; c++) begin
          cr[c] = m_active[16*row + 2*c];
          cg[c] = m_active[16*row + 2*c + 1];
        end
      end
    end
    q_exp.push_back({rs, cr, cg, sy, ak});
    @(posedge clk);
    #1;
    q_act.push_back({row_sel, col_r, col_g, frame_sync, frame_ack});
    frame_valid = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; frame_valid = 1'b0; frame_data = '0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({row_sel, col_r, col_g, frame_sync, frame_ack} !== {8'hFF, 8'h00, 8'h00, 2'b00}) begin
        errors++;
        $display("FAIL reset_outputs: got %h expected %h",
                 {row_sel, col_r, col_g, frame_sync, frame_ack}, {8'hFF, 16'h0, 2'b00});
      end
    end
    en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (row_sel !== 8'hFF || frame_sync !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold_en: row_sel %h sync %b expected FF 0", row_sel, frame_sync);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_frame();
    int n = 0;
    int acks = 0;
    logic [25:0] e, a;
    repeat (5) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 128'h1);
    repeat (70) cycle(1'b1, 1'b0, '0);
    while (q_act.size() > 0) begin
      e = q_exp.pop_front(); a = q_act.pop_front();
      acks += a[0];
      checks++;
      if (a !== e) begin errors++; $display("FAIL single_frame cyc%0d: got %h expected %h", n, a, e); end
      n++;
    end
    checks++;
    if (acks != 1) begin errors++; $display("FAIL single_frame_ack_count: got %0d expected 1", acks); end
  endtask

  task automatic test_row7();
    int n = 0;
    logic [127:0] d;
    logic [25:0] e, a;
    d = '0; d[16*7+15] = 1'b1;
    cycle(1'b1, 1'b1, d);
    while (((m_t + 1) % 32) != 0) cycle(1'b1, 1'b0, '0);
    repeat (33) cycle(1'b1, 1'b0, '0);
    while (q_act.size() > 0) begin
      e = q_exp.pop_front(); a = q_act.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL row7 cyc%0d: got %h expected %h", n, a, e); end
      n++;
    end
    checks++;
    if (m_active[127] !== 1'b1) begin errors++; $display("FAIL row7_model_loaded: got %b expected 1", m_active[127]); end
  endtask

  task automatic test_newest_wins();
    int n = 0;
    int acks = 0;
    logic [127:0] da, db;
    logic [25:0] e, a;
    da = rnd128(); db = ~da;
    cycle(1'b1, 1'b1, da);
    repeat (4) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, db);
    while (((m_t + 1) % 32) != 0) cycle(1'b1, 1'b0, '0);
    repeat (40) cycle(1'b1, 1'b0, '0);
    while (q_act.size() > 0) begin
      e = q_exp.pop_front(); a = q_act.pop_front();
      acks += a[0];
      checks++;
      if (a !== e) begin errors++; $display("FAIL newest_wins cyc%0d: got %h expected %h", n, a, e); end
      n++;
    end
    checks++;
    if (acks != 1) begin errors++; $display("FAIL newest_wins_ack_count: got %0d expected 1", acks); end
  endtask

  task automatic test_coincident();
    int n = 0;
    logic [25:0] e, a;
    while (((m_t + 1) % 32) != 0) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, rnd128());
    repeat (66) cycle(1'b1, 1'b0, '0);
    while (q_act.size() > 0) begin
      e = q_exp.pop_front(); a = q_act.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL coincident cyc%0d: got %h expected %h", n, a, e); end
      n++;
    end
  endtask

  task automatic test_en_drop();
    int n = 0;
    logic [25:0] e, a;
    cycle(1'b1, 1'b1, rnd128());
    while ((m_t % 32) != 13) cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, rnd128());
    cycle(1'b0, 1'b0, '0);
    repeat (70) cycle(1'b1, 1'b0, '0);
    while (q_act.size() > 0) begin
      e = q_exp.pop_front(); a = q_act.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL en_drop cyc%0d: got %h expected %h", n, a, e); end
      n++;
    end
  endtask

  task automatic test_free_run();
    int n = 0;
    int last_sync = -1;
    int lows;
    logic [25:0] e, a;
    cycle(1'b1, 1'b1, rnd128());
    while (((m_t + 1) % 32) != 0) cycle(1'b1, 1'b0, '0);
    repeat (96) cycle(1'b1, 1'b0, '0);
    while (q_act.size() > 0) begin
      e = q_exp.pop_front(); a = q_act.pop_front();
      checks++;
      if (a !== e) begin errors++; $display("FAIL free_run cyc%0d: got %h expected %h", n, a, e); end
      lows = 0;
      for (int b = 0; b < 8; b++) lows += (a[18+b] == 1'b0) ? 1 : 0;
      checks++;
      if (lows > 1) begin errors++; $display("FAIL free_run_onehot cyc%0d: row_sel %h expected at most one low", n, a[25:18]); end
      if (a[1]) begin
        if (last_sync >= 0) begin
          checks++;
          if (n - last_sync != 32) begin errors++; $display("FAIL free_run_period: got %0d expected 32", n - last_sync); end
        end
        last_sync = n;
      end
      n++;
    end
  endtask

  task automatic test_async_reset();
    repeat (6) cycle(1'b1, 1'b0, '0);
    q_exp.delete(); q_act.delete();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({row_sel, col_r, col_g, frame_sync, frame_ack} !== {8'hFF, 16'h0, 2'b00}) begin
      errors++;
      $display("FAIL async_reset_immediate: got %h expected %h",
               {row_sel, col_r, col_g, frame_sync, frame_ack}, {8'hFF, 16'h0, 2'b00});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    repeat (40) cycle(1'b1, 1'b0, '0);
    begin
      int n = 0;
      logic [25:0] e, a;
      while (q_act.size() > 0) begin
        e = q_exp.pop_front(); a = q_act.pop_front();
        checks++;
        if (a !== e) begin errors++; $display("FAIL async_reset_restart cyc%0d: got %h expected %h", n, a, e); end
        n++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_row7();
    test_newest_wins();
    test_coincident();
    test_en_drop();
    test_free_run();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_scan_driver.md
MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

Interface
REQ-001 The block SHALL have parameter DWELL, default 1000, giving clock cycles per row slot (125 Hz frame at 1 MHz clk).
REQ-002 The block SHALL have parameter BLANK, default 50, giving the anti-ghosting cycles at the start of each row slot; 1 <= BLANK < DWELL.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1, the scan enable; 0 means the panel is dark and the scan is parked.
REQ-006 The block SHALL have port frame_data, input, 128, the frame from the game matrix display; row r uses bits [16r+15:16r], column c red = bit 16r+2c, green = bit 16r+2c+1.
REQ-007 The block SHALL have port frame_valid, input, 1, a frame-load strobe; frame_data is sampled on every cycle it is high.
REQ-008 The block SHALL have port frame_ack, output, 1, a one-cycle pulse when a pending frame becomes the displayed frame.
REQ-009 The block SHALL have port frame_sync, output, 1, a one-cycle pulse in the first cycle of every row-0 slot.
REQ-010 The block SHALL have port row_sel, output, 8, active-low row drive with at most one bit low.
REQ-011 The block SHALL have port col_r, output, 8, active-high red column drive.
REQ-012 The block SHALL have port col_g, output, 8, active-high green column drive.

Function
REQ-013 The block SHALL hold three registers: shadow (128 b), active (128 b) and pending (1 b), plus row_idx (3 b) and slot counter cnt (0..DWELL-1).
REQ-014 The block SHALL implement a state machine with states IDLE (en=0), BLANK (cnt<BLANK) and DRIVE (cnt>=BLANK).
REQ-015 In IDLE the outputs SHALL be row_sel=8'hFF, col_r=0, col_g=0, with cnt=0 and row_idx=0.
REQ-016 On the first cycle with en=1 the block SHALL enter BLANK with row_idx=0, cnt=0, and frame_sync SHALL pulse that cycle.
REQ-017 cnt SHALL increment every enabled cycle; at DWELL-1 it SHALL wrap to 0 and row_idx SHALL increment, wrapping from 7 to 0.
REQ-018 In BLANK the outputs SHALL be row_sel=8'hFF, col_r=0, col_g=0.
REQ-019 In DRIVE row_sel SHALL be ~(1<<row_idx), col_r[c]=active[16*row_idx+2c] and col_g[c]=active[16*row_idx+2c+1].
REQ-020 All outputs SHALL be registered and aligned with the state and cnt described above; no output SHALL be driven combinationally from any input.
REQ-021 frame_valid=1 SHALL load shadow<=frame_data and set pending, overwriting any earlier pending frame (newest wins).
REQ-022 The frame boundary SHALL be the cycle in which frame_sync pulses; at that cycle, if pending=1, active<=shadow, pending clears and frame_ack pulses in the same cycle.
REQ-023 If frame_valid=1 on a boundary cycle, frame_data SHALL load directly into active, pending SHALL end at 0 and frame_ack SHALL pulse.
REQ-024 active SHALL change only at a boundary; a frame SHALL never be swapped mid-scan (no tearing).
REQ-025 Deasserting en mid-frame SHALL force IDLE on the next cycle; shadow, active and pending SHALL be retained, and no frame_ack SHALL issue while in IDLE.
REQ-026 Total row duty SHALL be (DWELL-BLANK)/DWELL per row slot, and the frame period SHALL be 8*DWELL cycles exactly.

Reset
REQ-027 While rst_n=0 the block SHALL hold row_sel=8'hFF, col_r=0, col_g=0, frame_ack=0, frame_sync=0, shadow=0, active=0, pending=0, row_idx=0, cnt=0 and state IDLE, independent of clk.
REQ-028 Reset asserted mid-scan SHALL blank the panel immediately (asynchronously), and the scan SHALL restart from the REQ-016 sequence after release with en=1.

Verification (DWELL=4, BLANK=1)
REQ-029 Reset, en=1, frame_valid pulse with frame_data=128'h1 -> frame_ack at the next frame_sync; row 0 DRIVE cycles show row_sel=8'hFE, col_r=8'h01, col_g=8'h00.
REQ-030 Display frame_data with bit 16*7+15 set -> during the row-7 DRIVE cycles row_sel=8'h7F, col_g=8'h80, col_r=0; all other rows show dark columns.
REQ-031 Two frame_valid pulses in one frame (A then B) -> a single frame_ack at the boundary and B displayed; A is never shown.
REQ-032 frame_valid coincident with frame_sync -> that frame_data is displayed starting from that row-0 slot, with pending=0 afterwards.
REQ-033 en dropped during the row-3 slot -> next cycle row_sel=8'hFF, cols 0; when en returns, frame_sync pulses and the scan restarts at row 0 with active unchanged.
REQ-034 Free run over 3 frames -> frame_sync every 32 cycles, each row low for exactly 3 consecutive cycles after 1 blank cycle, and row_sel is never more than one bit low.
